// File: rtl/c3lib_or_tree_pipe_if.sv
// Bundle of data/status signals around the pipelined OR tree.
// out_hit_cnt exists only when C3LIB_OR_TREE_HIT_CNT_EN is defined.
interface c3lib_or_tree_pipe_if #(
  parameter int NUM_IN = 8,
  parameter int WIDTH  = 1
);
  logic                    in_vld;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    sticky_clr;
  logic                    out_vld;
  logic [WIDTH-1:0]        out_data;
  logic                    out_any;
`ifdef C3LIB_OR_TREE_HIT_CNT_EN
  logic [15:0]             out_hit_cnt;
`endif

  modport master (
    output in_vld, in_data, sticky_clr,
`ifdef C3LIB_OR_TREE_HIT_CNT_EN
    input  out_hit_cnt,
`endif
    input  out_vld, out_data, out_any
  );

  modport slave (
    input  in_vld, in_data, sticky_clr,
`ifdef C3LIB_OR_TREE_HIT_CNT_EN
    output out_hit_cnt,
`endif
    output out_vld, out_data, out_any
  );
endinterface

// File: rtl/c3lib_or_tree_pipe.sv
// Pipelined NUM_IN x WIDTH OR reduction tree (fan-in GRP per level) with optional sticky output.
// Defining C3LIB_OR_TREE_HIT_CNT_EN adds a saturating count of non-zero results on out_hit_cnt.
module c3lib_or_tree_pipe #(
  parameter int NUM_IN = 8,
  parameter int WIDTH  = 1,
  parameter int GRP    = 4,
  parameter int STICKY = 0
) (
  input logic                clk,
  input logic                rst_n,
  c3lib_or_tree_pipe_if.slave bus
);

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int nodes_at(input int lvl);
    int n;
    n = NUM_IN;
    for (int i = 0; i < lvl; i++) n = ceil_div(n, GRP);
    return n;
  endfunction

  function automatic int calc_lat();
    int n;
    int l;
    n = NUM_IN;
    l = 0;
    while (n > 1) begin
      n = ceil_div(n, GRP);
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

  localparam int LAT = calc_lat();

  logic [LAT:1]     vld_q;
  logic [LAT:0]     stg_vld;
  logic [WIDTH-1:0] lvl_d [1:LAT][0:NUM_IN-1];
  logic [WIDTH-1:0] lvl_q [1:LAT][0:NUM_IN-1];
  logic [WIDTH-1:0] result;
  logic             result_ld;

  assign stg_vld   = {vld_q, bus.in_vld};
  assign result    = lvl_d[LAT][0];
  assign result_ld = stg_vld[LAT-1];
  assign bus.out_vld = vld_q[LAT];

  // Nodes past the end of the previous level are never wired in, so partial groups OR in zeros.
  for (genvar l = 1; l <= LAT; l++) begin : g_lvl
    localparam int NPREV = nodes_at(l - 1);
    for (genvar j = 0; j < NUM_IN; j++) begin : g_node
      logic [WIDTH-1:0] part [0:GRP];
      assign part[0] = '0;
      for (genvar g = 0; g < GRP; g++) begin : g_in
        if (j * GRP + g < NPREV) begin : g_use
          if (l == 1) begin : g_src_in
            assign part[g+1] = part[g] | bus.in_data[(j*GRP+g)*WIDTH +: WIDTH];
          end else begin : g_src_lvl
            assign part[g+1] = part[g] | lvl_q[l-1][j*GRP+g];
          end
        end else begin : g_pad
          assign part[g+1] = part[g];
        end
      end
      assign lvl_d[l][j] = part[GRP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int l = 1; l <= LAT; l++)
        for (int j = 0; j < NUM_IN; j++)
          lvl_q[l][j] <= '0;
    end else begin
      vld_q <= stg_vld[LAT-1:0];
      for (int l = 1; l <= LAT; l++)
        for (int j = 0; j < NUM_IN; j++)
          if (stg_vld[l-1]) lvl_q[l][j] <= lvl_d[l][j];
    end
  end

  if (STICKY != 0) begin : g_sticky
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             any_q;

    // A clear that lands with a result keeps that result, so no event is dropped.
    always_comb begin
      acc_d = acc_q;
      if (result_ld) acc_d = bus.sticky_clr ? result : (acc_q | result);
      else if (bus.sticky_clr) acc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        any_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        any_q <= |acc_d;
      end
    end

    assign bus.out_data = acc_q;
    assign bus.out_any  = any_q;
  end else begin : g_plain
    logic any_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) any_q <= 1'b0;
      else if (result_ld) any_q <= |result;
    end

    assign bus.out_data = lvl_q[LAT][0];
    assign bus.out_any  = any_q;
  end

`ifdef C3LIB_OR_TREE_HIT_CNT_EN
  logic [15:0] hit_cnt_q;
  logic        hit;

  // Counts raw tree results, independent of the sticky accumulator.
  assign hit = result_ld && (result != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_q <= '0;
    else if (bus.sticky_clr) hit_cnt_q <= {15'd0, hit};
    else if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
  end

  assign bus.out_hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_c3lib_or_tree_pipe.sv
// Bench for c3lib_or_tree_pipe: three instances (8x4 plain, 8x4 sticky, 5x1 GRP=2) against a cycle-history model.
// Hit counter checks are included when C3LIB_OR_TREE_HIT_CNT_EN is defined.
`timescale 1ns/1ps
module tb_c3lib_or_tree_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  // Input history per clock edge; a result equals the OR of inputs taken LAT-1 edges earlier.
  int          ecount   = 0;
  int          rst_edge = 0;
  bit          vld_h  [0:4095];
  logic [31:0] data_h [0:4095];

  bit          ev_a, ev_b, ev_c;
  logic [3:0]  ed_a, ed_b;
  logic        ed_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  always #5 clk = ~clk;

  c3lib_or_tree_pipe_if #(.NUM_IN(8), .WIDTH(4)) bus_a ();
  c3lib_or_tree_pipe_if #(.NUM_IN(8), .WIDTH(4)) bus_b ();
  c3lib_or_tree_pipe_if #(.NUM_IN(5), .WIDTH(1)) bus_c ();

  c3lib_or_tree_pipe #(.NUM_IN(8), .WIDTH(4), .GRP(4), .STICKY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  c3lib_or_tree_pipe #(.NUM_IN(8), .WIDTH(4), .GRP(4), .STICKY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  c3lib_or_tree_pipe #(.NUM_IN(5), .WIDTH(1), .GRP(2), .STICKY(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  function automatic logic [3:0] or_nibbles(input logic [31:0] d);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = r | d[k*4 +: 4];
    return r;
  endfunction

  function automatic logic [31:0] hist_data(input int lat);
    int idx;
    idx = ecount - lat + 1;
    return (idx > rst_edge) ? data_h[idx] : 32'h0;
  endfunction

  function automatic bit hist_vld(input int lat);
    int idx;
    idx = ecount - lat + 1;
    return (idx > rst_edge) ? vld_h[idx] : 1'b0;
  endfunction

  function automatic logic [15:0] next_cnt(input logic [15:0] c, input bit hit, input bit clr);
    if (clr) return hit ? 16'd1 : 16'd0;
    if (hit && c != 16'hFFFF) return c + 16'd1;
    return c;
  endfunction

  task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    compare("a_vld",  16'(bus_a.out_vld),  16'(ev_a));
    compare("a_data", 16'(bus_a.out_data), 16'(ed_a));
    compare("a_any",  16'(bus_a.out_any),  16'(|ed_a));
    compare("b_vld",  16'(bus_b.out_vld),  16'(ev_b));
    compare("b_data", 16'(bus_b.out_data), 16'(ed_b));
    compare("b_any",  16'(bus_b.out_any),  16'(|ed_b));
    compare("c_vld",  16'(bus_c.out_vld),  16'(ev_c));
    compare("c_data", 16'(bus_c.out_data), 16'(ed_c));
    compare("c_any",  16'(bus_c.out_any),  16'(ed_c));
`ifdef C3LIB_OR_TREE_HIT_CNT_EN
    compare("a_hit",  bus_a.out_hit_cnt, cnt_a);
    compare("b_hit",  bus_b.out_hit_cnt, cnt_b);
    compare("c_hit",  bus_c.out_hit_cnt, cnt_c);
`endif
  endtask

  task automatic driveInputs(input bit vld, input logic [31:0] data, input bit clr);
    bus_a.in_vld = vld; bus_a.in_data = data; bus_a.sticky_clr = clr;
    bus_b.in_vld = vld; bus_b.in_data = data; bus_b.sticky_clr = clr;
    bus_c.in_vld = vld; bus_c.in_data = data[4:0]; bus_c.sticky_clr = clr;
  endtask

  // One clock: drive, clock, advance the model, compare.
  task automatic applyStimulus(input bit vld, input logic [31:0] data, input bit clr);
    logic [3:0]  ra;
    logic [31:0] dc;
    bit          va, vc, rc;
    driveInputs(vld, data, clr);
    @(posedge clk);
    #1;
    ecount++;
    vld_h[ecount]  = vld;
    data_h[ecount] = data;

    va = hist_vld(2);
    ra = or_nibbles(hist_data(2));
    vc = hist_vld(3);
    dc = hist_data(3);
    rc = |dc[4:0];

    cnt_a = next_cnt(cnt_a, va && (ra != 4'h0), clr);
    cnt_b = next_cnt(cnt_b, va && (ra != 4'h0), clr);
    cnt_c = next_cnt(cnt_c, vc && rc, clr);

    ev_a = va;
    if (va) ed_a = ra;
    ev_b = va;
    if (va) ed_b = clr ? ra : (ed_b | ra);
    else if (clr) ed_b = 4'h0;
    ev_c = vc;
    if (vc) ed_c = rc;

    checkOutput();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_edge = ecount;
    ev_a = 0; ev_b = 0; ev_c = 0;
    ed_a = '0; ed_b = '0; ed_c = 1'b0;
    cnt_a = '0; cnt_b = '0; cnt_c = '0;
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    driveInputs(1'b0, 32'h0, 1'b0);
    #1;
    pulseReset();

    // Single hot vector 5 = 4'h8, then idle until it drains.
    applyStimulus(1'b1, 32'h0080_0000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);

    // Back-to-back 1, 2, 0 on vector 0.
    applyStimulus(1'b1, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);

    // Sticky: 1, 4 accumulate; clear with result 2; clear alone.
    applyStimulus(1'b1, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Partial group: only vector 4 of the 5x1 instance set.
    applyStimulus(1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);

    // Invalid cycles with all-ones data must not load.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0);

    // Reset with two results in flight.
    applyStimulus(1'b1, 32'h0000_0300, 1'b0);
    applyStimulus(1'b1, 32'h0000_001F, 1'b0);
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0);

    // Hit counting: three non-zero and two zero results, then a clear coinciding with a hit.
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h11, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h2000_0000, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h10, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);

`ifdef C3LIB_OR_TREE_HIT_CNT_EN
    // Preload near saturation, then keep hitting.
    dut_a.hit_cnt_q = 16'hFFFE;
    cnt_a = 16'hFFFE;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);
`endif

    // Randomised traffic with sparse data and occasional clears.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0) d = 32'h0;
      applyStimulus($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/c3lib_or_tree_pipe.md
Name: c3lib_or_tree_pipe

Overview:
- Parametrised, pipelined N-input, W-bit OR reduction tree with valid tracking and an optional sticky (accumulate-until-clear) output mode.
- Next-generation replacement for the fixed 2-input OR primitives in the c3lib library.
- Used for wide error/status aggregation across AIB channels, where a flat OR cannot meet timing.
- Sits between per-channel status sources and CSR/interrupt logic.

Parameters:
- NUM_IN, 8: number of input vectors OR-ed together; legal range 1..64.
- WIDTH, 1: bit width of each input vector and of the result; legal range 1..32.
- GRP, 4: fan-in per tree level; legal values 2, 4, 8.
- STICKY, 0: 0 = out_data shows the latest tree result; 1 = out_data accumulates results until cleared.
- Derived localparam LAT = max(1, ceil(log_GRP(NUM_IN))): pipeline depth in clocks.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- in_vld  input  1  in_data qualifier for this cycle.
- in_data  input  NUM_IN*WIDTH  packed inputs; vector k occupies bits [k*WIDTH +: WIDTH].
- sticky_clr  input  1  clears the sticky accumulator (ignored when STICKY=0).
- out_vld  output  1  out_data/out_any updated this cycle.
- out_data  output  WIDTH  bitwise OR of all NUM_IN vectors (or the accumulated value in sticky mode).
- out_any  output  1  reduction OR of out_data.
- out_hit_cnt  output  16  present only with the optional feature.

Behaviour:
- Reset: all outputs and all pipeline registers are 0, including the valid shift chain and the accumulator.
- Asynchronous assertion takes effect immediately and aborts any in-flight data.
- Tree structure:
  - Level 0 splits the NUM_IN vectors into ceil(NUM_IN/GRP) groups. The last group may be partial; missing inputs are treated as 0.
  - Each level ORs its group and registers the result.
  - Levels repeat until one vector remains. NUM_IN=1 still gets one register stage.
- Latency: out_vld = in_vld delayed exactly LAT cycles; out_data is the OR of the in_data sampled in that same cycle.
- Throughput: one result per clock, with no back-pressure and no bubbles.
- Data registers load only when the stage valid is 1, so out_data holds its last value while out_vld=0.
- Non-sticky mode (STICKY=0): out_data = tree result whenever the final-stage valid is 1; otherwise it holds.
- Sticky mode (STICKY=1): the accumulator updates at the final stage.
  - valid=1, clr=0: acc <= acc | result.
  - valid=1, clr=1: acc <= result. The clear drops old history but keeps the same-cycle result, so no event is lost.
  - valid=0, clr=1: acc <= 0.
  - valid=0, clr=0: hold.
  - out_data = acc. out_vld still follows the delayed valid chain.
- out_any is registered together with out_data and equals |out_data at all times.
- X on in_data while in_vld=0 must not propagate: data registers do not load.
- Reset during operation: the pipeline empties and out_vld stays 0 for LAT cycles after the first post-reset in_vld.

Optional Feature:
- Macro: C3LIB_OR_TREE_HIT_CNT_EN.
- When defined:
  - Adds the out_hit_cnt[15:0] port.
  - Counts cycles where out_vld=1 and the final-stage tree result is non-zero; the count uses the raw result, not the sticky value.
  - Saturates at 16'hFFFF.
  - Clears to 0 on reset, or on sticky_clr=1 in any STICKY mode.
  - If clear and hit coincide, the counter loads 1.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- NUM_IN=8, WIDTH=4, GRP=4 (LAT=2): in_vld=1, vector 5=4'h8, others 0 -> two cycles later out_vld=1, out_data=4'h8, out_any=1.
- Back-to-back in_vld on 3 cycles with vector 0 = 4'h1, 4'h2, 4'h0 -> out_data = 4'h1, 4'h2, 4'h0 on consecutive cycles; out_any = 1, 1, 0.
- STICKY=1: results 4'h1 then 4'h4 -> out_data = 4'h1, then 4'h5. Then sticky_clr=1 in the same cycle as result 4'h2 -> out_data=4'h2. Then sticky_clr alone -> out_data=4'h0.
- NUM_IN=5, GRP=2 (LAT=3, partial groups): only vector 4 = 1 -> out_data=1 after 3 cycles. in_vld=0 with in_data all ones -> out_vld stays 0 and out_data holds.
- rst_n pulsed low while 2 results are in flight -> outputs go to 0 immediately; no out_vld appears afterwards without new in_vld.
- With C3LIB_OR_TREE_HIT_CNT_EN: 3 non-zero results and 2 zero results -> out_hit_cnt=3. sticky_clr coincident with a hit -> out_hit_cnt=1. Forcing the count to 16'hFFFF plus one more hit -> stays at 16'hFFFF.
